// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner with load shadowing and a one-cycle dead slot per digit.
// Optional per-digit blink is compiled in with `define SEG_SCAN_BLINK_EN.
module seg_scan_driver #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   digit_val,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DIGITS-1:0]     dp,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [DIGITS-1:0]     blink,
`endif
    input  logic                  load,
    output logic [7:0]            seg_ctrl,
    output logic [DIGITS-1:0]     seg_out,
    output logic                  frame_start
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("DIGITS must be 1..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("SCAN_DIV must be at least 2");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("BLINK_FRAMES must be at least 1");
    end

    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [4*DIGITS-1:0] shadow_val_reg;
    logic [DIGITS-1:0]   shadow_en_reg;
    logic [DIGITS-1:0]   shadow_dp_reg;
    logic [7:0]          seg_ctrl_reg, seg_ctrl_next;
    logic [DIGITS-1:0]   seg_out_reg, seg_out_next;
    logic                frame_start_reg, frame_start_next;
    logic                phase_blank;
    logic [3:0]          nib [DIGITS];

    function automatic logic [7:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 8'hFC;  4'h1: hex7 = 8'h60;
            4'h2: hex7 = 8'hDA;  4'h3: hex7 = 8'hF2;
            4'h4: hex7 = 8'h66;  4'h5: hex7 = 8'hB6;
            4'h6: hex7 = 8'hBE;  4'h7: hex7 = 8'hE0;
            4'h8: hex7 = 8'hFE;  4'h9: hex7 = 8'hF6;
            4'hA: hex7 = 8'hEE;  4'hB: hex7 = 8'h3E;
            4'hC: hex7 = 8'h9C;  4'hD: hex7 = 8'h7A;
            4'hE: hex7 = 8'h9E;  default: hex7 = 8'h8E;
        endcase
    endfunction

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign nib[gi] = shadow_val_reg[4*gi +: 4];
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

    logic [DIGITS-1:0] shadow_blink_reg;
    logic [FR_W-1:0]   frame_cnt_reg;
    logic              phase_reg;

    // Frame counter steps at the last cycle of a frame so the new phase applies from slot 0 onward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_blink_reg <= '0;
            frame_cnt_reg    <= '0;
            phase_reg        <= 1'b0;
        end else begin
            if (load)
                shadow_blink_reg <= blink;
            if (cnt_reg == CNT_LAST && idx_reg == IDX_LAST) begin
                if (frame_cnt_reg == FR_LAST) begin
                    frame_cnt_reg <= '0;
                    phase_reg     <= ~phase_reg;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign phase_blank = phase_reg & shadow_blink_reg[idx_reg];
`else
    assign phase_blank = 1'b0;
`endif

    always_comb begin
        cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
        idx_next = idx_reg;
        if (cnt_reg == CNT_LAST)
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end

    always_comb begin
        seg_out_next     = '0;
        seg_ctrl_next    = '0;
        frame_start_next = (cnt_reg == '0) && (idx_reg == '0);
        if (cnt_reg != '0 && shadow_en_reg[idx_reg] && !phase_blank) begin
            seg_out_next  = DIGITS'(1) << idx_reg;
            seg_ctrl_next = hex7(nib[idx_reg]) | {7'b0, shadow_dp_reg[idx_reg]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg         <= '0;
            idx_reg         <= '0;
            shadow_val_reg  <= '0;
            shadow_en_reg   <= '0;
            shadow_dp_reg   <= '0;
            seg_ctrl_reg    <= '0;
            seg_out_reg     <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            idx_reg         <= idx_next;
            seg_ctrl_reg    <= seg_ctrl_next;
            seg_out_reg     <= seg_out_next;
            frame_start_reg <= frame_start_next;
            if (load) begin
                shadow_val_reg <= digit_val;
                shadow_en_reg  <= digit_en;
                shadow_dp_reg  <= dp;
            end
        end
    end

    assign seg_ctrl    = seg_ctrl_reg;
    assign seg_out     = seg_out_reg;
    assign frame_start = frame_start_reg;

endmodule
